// File: rtl/bidir_bus_ctrl.sv
// Half-duplex sequencer for a shared bidirectional pad bus built from buf_io cells.
// Arbitrates write/read requesters and inserts a turnaround after every driven phase.
module bidir_bus_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DRV_CYC = 2,
    parameter int TA_CYC  = 1,
    parameter int RD_LAT  = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] buf_t,
    output logic [DATA_W-1:0] buf_i,
    input  logic [DATA_W-1:0] buf_o,
    output logic              busy
);

    localparam int MAX_CYC = (DRV_CYC > TA_CYC) ? ((DRV_CYC > RD_LAT) ? DRV_CYC : RD_LAT)
                                                : ((TA_CYC > RD_LAT) ? TA_CYC : RD_LAT);
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DRV_LOAD = CNT_W'(DRV_CYC - 1);
    localparam logic [CNT_W-1:0] TA_LOAD  = (TA_CYC > 0) ? CNT_W'(TA_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;
    typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

    state_t            state, state_n;
    grant_t            last_grant, last_grant_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] buf_t_n, buf_i_n, rd_data_n;
    logic              wr_ack_n, rd_ack_n, busy_n;
    logic              wr_elig, rd_elig, grant_wr, grant_rd;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
            cnt        <= '0;
            buf_t      <= '1;
            buf_i      <= '0;
            rd_data    <= '0;
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
            state      <= state_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            buf_t      <= buf_t_n;
            buf_i      <= buf_i_n;
            rd_data    <= rd_data_n;
            wr_ack     <= wr_ack_n;
            rd_ack     <= rd_ack_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves a latch.
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        buf_t_n      = buf_t;
        buf_i_n      = buf_i;
        rd_data_n    = rd_data;
        wr_ack_n     = 1'b0;
        rd_ack_n     = 1'b0;

        // A requester whose ack is still visible is dropping its request, not asking again.
        wr_elig  = wr_req && !wr_ack;
        rd_elig  = rd_req && !rd_ack;
        grant_wr = 1'b0;
        grant_rd = 1'b0;

        unique case (state)
            IDLE: begin
                buf_t_n  = '1;
                grant_wr = wr_elig && (!rd_elig || (last_grant == GRANT_RD));
                grant_rd = rd_elig && !grant_wr;
                if (grant_wr) begin
                    buf_i_n      = wr_data;
                    buf_t_n      = '0;
                    cnt_n        = DRV_LOAD;
                    state_n      = DRIVE;
                    last_grant_n = GRANT_WR;
                    wr_ack_n     = (DRV_CYC == 1);
                end else if (grant_rd) begin
                    cnt_n        = RD_LOAD;
                    state_n      = SAMPLE;
                    last_grant_n = GRANT_RD;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    buf_t_n = '1;
                    if (TA_CYC > 0) begin
                        state_n = TURN;
                        cnt_n   = TA_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n    = cnt - CNT_ONE;
                    // ack is registered, so raise it one cycle ahead of the last driven cycle
                    wr_ack_n = (cnt == CNT_ONE);
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            SAMPLE: begin
                if (cnt == '0) begin
                    rd_data_n = buf_o;
                    rd_ack_n  = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                buf_t_n = '1;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: two instances (default timing and DRV_CYC=1/TA_CYC=0) checked
// every cycle against a transaction-timeline reference model, plus directed checks.
module tb_bidir_bus_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         wr_req [2];
    logic         rd_req [2];
    logic         wr_ack [2];
    logic         rd_ack [2];
    logic         busy   [2];
    logic [W-1:0] wr_data[2];
    logic [W-1:0] rd_data[2];
    logic [W-1:0] buf_t  [2];
    logic [W-1:0] buf_i  [2];
    logic [W-1:0] buf_o  [2];

    bidir_bus_ctrl #(.DATA_W(W)) u_dut0 (
        .CLK(clk), .RESET_N(rst_n),
        .wr_req(wr_req[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
        .rd_req(rd_req[0]), .rd_ack(rd_ack[0]), .rd_data(rd_data[0]),
        .buf_t(buf_t[0]), .buf_i(buf_i[0]), .buf_o(buf_o[0]), .busy(busy[0])
    );

    bidir_bus_ctrl #(.DATA_W(W), .DRV_CYC(1), .TA_CYC(0), .RD_LAT(2)) u_dut1 (
        .CLK(clk), .RESET_N(rst_n),
        .wr_req(wr_req[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
        .rd_req(rd_req[1]), .rd_ack(rd_ack[1]), .rd_data(rd_data[1]),
        .buf_t(buf_t[1]), .buf_i(buf_i[1]), .buf_o(buf_o[1]), .busy(busy[1])
    );

    function automatic int p_drv(input int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int p_ta (input int k); return (k == 0) ? 1 : 0; endfunction
    function automatic int p_lat(input int k); return (k == 0) ? 2 : 2; endfunction

    // Reference model: a timeline of the one transaction in flight per instance.
    typedef struct {
        int           free_at;
        bit           last_wr;
        int           drv_lo, drv_hi, busy_lo, busy_hi;
        int           wack, rack, rsamp;
        logic [W-1:0] exp_i, exp_rd, pend_i, pend_rd;
        int           pend_i_at, pend_rd_at;
    } model_t;

    model_t m[2];
    int     cyc = 0;
    int     nchk = 0;
    int     nfail = 0;
    bit     in_reset;
    bit     release_now = 0;

    int           wr_mode[2];   // 0: one-shot, 1: always re-assert, 2: random
    int           rd_mode[2];
    bit           shot_wr[2], shot_rd[2];
    logic [W-1:0] shot_wd[2];
    bit           fix_o = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].free_at    = 1 << 30;
            m[k].last_wr    = 1'b0;
            m[k].drv_lo     = -10; m[k].drv_hi  = -11;
            m[k].busy_lo    = -10; m[k].busy_hi = -11;
            m[k].wack       = -10; m[k].rack    = -10; m[k].rsamp = -10;
            m[k].exp_i      = '0;  m[k].exp_rd  = '0;
            m[k].pend_i     = '0;  m[k].pend_rd = '0;
            m[k].pend_i_at  = -10; m[k].pend_rd_at = -10;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] exp_t;
            if (cyc == m[k].pend_i_at)  m[k].exp_i  = m[k].pend_i;
            if (cyc == m[k].pend_rd_at) m[k].exp_rd = m[k].pend_rd;
            exp_t = (cyc >= m[k].drv_lo && cyc <= m[k].drv_hi) ? '0 : '1;
            chk($sformatf("buf_t%0d", k), 32'(buf_t[k]), 32'(exp_t));
            chk($sformatf("buf_i%0d", k), 32'(buf_i[k]), 32'(m[k].exp_i));
            chk($sformatf("wr_ack%0d", k), 32'(wr_ack[k]), 32'(cyc == m[k].wack));
            chk($sformatf("rd_ack%0d", k), 32'(rd_ack[k]), 32'(cyc == m[k].rack));
            chk($sformatf("rd_data%0d", k), 32'(rd_data[k]), 32'(m[k].exp_rd));
            chk($sformatf("busy%0d", k), 32'(busy[k]),
                32'(cyc >= m[k].busy_lo && cyc <= m[k].busy_hi));
            chk($sformatf("ack_excl%0d", k), 32'(wr_ack[k] & rd_ack[k]), 32'(0));
        end
    endtask

    task automatic drive_requesters();
        for (int k = 0; k < 2; k++) begin
            if (wr_req[k] && wr_ack[k]) begin
                if (wr_mode[k] == 1 || (wr_mode[k] == 2 && $urandom_range(0, 1) == 1))
                    wr_data[k] = W'($urandom);
                else
                    wr_req[k] = 1'b0;
            end else if (!wr_req[k]) begin
                if (shot_wr[k]) begin
                    wr_req[k] = 1'b1; wr_data[k] = shot_wd[k]; shot_wr[k] = 1'b0;
                end else if (wr_mode[k] == 1 || (wr_mode[k] == 2 && $urandom_range(0, 2) == 0)) begin
                    wr_req[k] = 1'b1; wr_data[k] = W'($urandom);
                end
            end
            if (rd_req[k] && rd_ack[k]) begin
                if (!(rd_mode[k] == 1 || (rd_mode[k] == 2 && $urandom_range(0, 1) == 1)))
                    rd_req[k] = 1'b0;
            end else if (!rd_req[k]) begin
                if (shot_rd[k]) begin
                    rd_req[k] = 1'b1; shot_rd[k] = 1'b0;
                end else if (rd_mode[k] == 1 || (rd_mode[k] == 2 && $urandom_range(0, 2) == 0)) begin
                    rd_req[k] = 1'b1;
                end
            end
            if (!fix_o) buf_o[k] = W'($urandom);
        end
    endtask

    task automatic model_decide();
        for (int k = 0; k < 2; k++) begin
            bit we, re, gw, gr;
            if (cyc == m[k].rsamp) begin
                m[k].pend_rd    = buf_o[k];
                m[k].pend_rd_at = cyc + 1;
            end
            if (!in_reset && cyc >= m[k].free_at) begin
                we = wr_req[k] && (cyc != m[k].wack);
                re = rd_req[k] && (cyc != m[k].rack);
                gw = we && (!re || !m[k].last_wr);
                gr = re && !gw;
                if (gw) begin
                    m[k].drv_lo    = cyc + 1;
                    m[k].drv_hi    = cyc + p_drv(k);
                    m[k].wack      = cyc + p_drv(k);
                    m[k].busy_lo   = cyc + 1;
                    m[k].busy_hi   = cyc + p_drv(k) + p_ta(k);
                    m[k].free_at   = cyc + p_drv(k) + p_ta(k) + 1;
                    m[k].pend_i    = wr_data[k];
                    m[k].pend_i_at = cyc + 1;
                    m[k].last_wr   = 1'b1;
                end else if (gr) begin
                    m[k].rsamp   = cyc + p_lat(k);
                    m[k].rack    = cyc + p_lat(k) + 1;
                    m[k].busy_lo = cyc + 1;
                    m[k].busy_hi = cyc + p_lat(k);
                    m[k].free_at = cyc + p_lat(k) + 1;
                    m[k].last_wr = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (release_now) begin
            rst_n       = 1'b1;
            in_reset    = 1'b0;
            release_now = 1'b0;
            for (int k = 0; k < 2; k++) m[k].free_at = cyc;
        end
        drive_requesters();
        model_decide();
    endtask

    bit ack_log[$];
    int last_drv0;
    int last_wack1;
    int g;
    bit got_ack;

    initial begin
        for (int k = 0; k < 2; k++) begin
            wr_mode[k] = 0; rd_mode[k] = 0;
            shot_wr[k] = 1'b0; shot_rd[k] = 1'b0; shot_wd[k] = '0;
            rd_req[k]  = 1'b0; buf_o[k] = '0;
        end
        // Both requesters hold a write across reset.
        wr_req[0] = 1'b1; wr_data[0] = 8'hA5;
        wr_req[1] = 1'b1; wr_data[1] = 8'hC3;
        in_reset = 1'b1;
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state with a write request pending.
        repeat (3) tick();
        chk("rst_buf_t", 32'(buf_t[0]), 32'h0000_00FF);
        chk("rst_wr_ack", 32'(wr_ack[0]), 32'(0));
        chk("rst_busy", 32'(busy[0]), 32'(0));

        // Release: the held write is granted in the first IDLE cycle and drives 2 cycles.
        release_now = 1'b1;
        tick();
        tick();
        chk("wr1_t_a", 32'(buf_t[0]), 32'h0000_0000);
        chk("wr1_i_a", 32'(buf_i[0]), 32'h0000_00A5);
        chk("wr1_ack_a", 32'(wr_ack[0]), 32'(0));
        tick();
        chk("wr1_t_b", 32'(buf_t[0]), 32'h0000_0000);
        chk("wr1_i_b", 32'(buf_i[0]), 32'h0000_00A5);
        chk("wr1_ack_b", 32'(wr_ack[0]), 32'(1));
        tick();
        chk("wr1_turn_t", 32'(buf_t[0]), 32'h0000_00FF);
        chk("wr1_turn_busy", 32'(busy[0]), 32'(1));
        chk("wr1_turn_ack", 32'(wr_ack[0]), 32'(0));
        tick();
        chk("wr1_idle_busy", 32'(busy[0]), 32'(0));
        repeat (3) tick();

        // Single read: pad holds 0x3C, ack arrives RD_LAT+1 cycles after the grant.
        buf_o[0] = 8'h3C;
        shot_rd[0] = 1'b1;
        tick();
        g = cyc;
        repeat (2) begin
            tick();
            chk("rd1_t", 32'(buf_t[0]), 32'h0000_00FF);
            chk("rd1_busy", 32'(busy[0]), 32'(1));
            chk("rd1_ack_early", 32'(rd_ack[0]), 32'(0));
        end
        tick();
        chk("rd1_latency", 32'(cyc - g), 32'(3));
        chk("rd1_ack", 32'(rd_ack[0]), 32'(1));
        chk("rd1_data", 32'(rd_data[0]), 32'h0000_003C);
        chk("rd1_t_end", 32'(buf_t[0]), 32'h0000_00FF);
        repeat (3) tick();

        // Simultaneous held requests on inst 0; back-to-back writes on inst 1.
        fix_o = 1'b0;
        wr_mode[0] = 1; rd_mode[0] = 1; wr_mode[1] = 1;
        last_drv0 = -100;
        last_wack1 = -1;
        repeat (40) begin
            tick();
            if (buf_t[0] == '0) last_drv0 = cyc;
            if (wr_ack[0]) ack_log.push_back(1'b1);
            if (rd_ack[0]) begin
                ack_log.push_back(1'b0);
                // released cycles between last drive and the sample cycle (cyc-1)
                chk("ta_gap", 32'((cyc - 1 - last_drv0 - 1) >= p_ta(0)), 32'(1));
            end
            if (buf_t[1] == '0 && last_wack1 >= 0) begin
                chk("b2b_gap", 32'(cyc - last_wack1), 32'(2));
                last_wack1 = -1;
            end
            if (wr_ack[1]) last_wack1 = cyc;
        end
        chk("alt_count", 32'(ack_log.size() >= 4), 32'(1));
        for (int i = 0; i < 4; i++) begin
            if (i < ack_log.size())
                chk($sformatf("alt_%0d", i), 32'(ack_log[i]), 32'(i % 2 == 0));
        end
        wr_mode[0] = 0; rd_mode[0] = 0; wr_mode[1] = 0;
        repeat (12) tick();

        // Reset in the first DRIVE cycle aborts the write; the held request is reissued.
        shot_wr[0] = 1'b1; shot_wd[0] = 8'h5A;
        tick();
        tick();
        chk("abort_drive", 32'(buf_t[0]), 32'h0000_0000);
        rst_n = 1'b0;
        in_reset = 1'b1;
        model_reset();
        #1;
        chk("abort_t_async", 32'(buf_t[0]), 32'h0000_00FF);
        chk("abort_busy", 32'(busy[0]), 32'(0));
        chk("abort_ack", 32'(wr_ack[0]), 32'(0));
        repeat (2) tick();
        release_now = 1'b1;
        got_ack = 1'b0;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            tick();
            if (wr_ack[0]) begin
                got_ack = 1'b1;
                chk("reissue_data", 32'(buf_i[0]), 32'h0000_005A);
            end
        end
        chk("reissue_done", 32'(got_ack), 32'(1));
        repeat (4) tick();

        // Random traffic on both instances.
        for (int k = 0; k < 2; k++) begin
            wr_mode[k] = 2; rd_mode[k] = 2;
        end
        repeat (500) tick();
        for (int k = 0; k < 2; k++) begin
            wr_mode[k] = 0; rd_mode[k] = 0;
        end
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
